// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the iterative divide unit.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_core.sv
// Unsigned restoring shift-subtract datapath: one quotient bit per step.
module div_core
    import riscv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_last,
    output logic [XLEN-1:0] o_quot_nxt,
    output logic [XLEN-1:0] o_rem_nxt
);

    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quot;
    logic [XLEN-1:0]  r_divisor;
    logic [CNT_W-1:0] r_count;

    logic [XLEN:0]    w_shift;
    logic             w_ge;
    logic [XLEN-1:0]  w_rem_nxt;
    logic [XLEN-1:0]  w_quot_nxt;

    // The shifted remainder needs XLEN+1 bits; after the restore step it fits in XLEN again.
    always_comb begin
        w_shift    = {r_rem, r_quot[XLEN-1]};
        w_ge       = w_shift >= {1'b0, r_divisor};
        w_rem_nxt  = w_ge ? (w_shift[XLEN-1:0] - r_divisor) : w_shift[XLEN-1:0];
        w_quot_nxt = {r_quot[XLEN-2:0], w_ge};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_count   <= '0;
        end else if (i_load) begin
            r_rem     <= '0;
            r_quot    <= i_dividend;
            r_divisor <= i_divisor;
            r_count   <= CNT_W'(XLEN);
        end else if (i_step) begin
            r_rem     <= w_rem_nxt;
            r_quot    <= w_quot_nxt;
            r_count   <= r_count - CNT_W'(1);
        end
    end

    assign o_last     = (r_count == CNT_W'(1));
    assign o_quot_nxt = w_quot_nxt;
    assign o_rem_nxt  = w_rem_nxt;

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit with pipeline stall; define DIV_SHORTCUT_EN to
// finish divide-by-zero and signed overflow in a single cycle.
module div_unit
    import riscv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    div_state_e      r_state, w_state_nxt;
    logic            r_is_rem, r_neg_q, r_neg_r;
    logic [XLEN-1:0] r_result, w_result_nxt;

    div_op_e         w_op;
    logic            w_signed, w_a_neg, w_b_neg, w_b_zero;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_load, w_step, w_last;
    logic [XLEN-1:0] w_q, w_r, w_fin;

    assign w_op     = div_op_e'(i_op);
    assign w_signed = (w_op == OpDiv) || (w_op == OpRem);
    assign w_a_neg  = w_signed & i_a[XLEN-1];
    assign w_b_neg  = w_signed & i_b[XLEN-1];
    assign w_b_zero = (i_b == '0);
    assign w_a_mag  = w_a_neg ? (XLEN'(0) - i_a) : i_a;
    assign w_b_mag  = w_b_neg ? (XLEN'(0) - i_b) : i_b;

`ifdef DIV_SHORTCUT_EN
    logic            w_ovf, w_shortcut;
    logic [XLEN-1:0] w_short_res;

    assign w_ovf       = w_signed & (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_b == '1);
    assign w_shortcut  = w_b_zero | w_ovf;
    assign w_short_res = i_op[1] ? (w_b_zero ? i_a : '0)
                                 : (w_b_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}});
`endif

    div_core u_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_last     (w_last),
        .o_quot_nxt (w_q),
        .o_rem_nxt  (w_r)
    );

    // Quotient is never negated for b==0 so it stays all-ones.
    assign w_fin = r_is_rem ? (r_neg_r ? (XLEN'(0) - w_r) : w_r)
                            : (r_neg_q ? (XLEN'(0) - w_q) : w_q);

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
`ifdef DIV_SHORTCUT_EN
                    if (w_shortcut) begin
                        w_state_nxt  = StDone;
                        w_result_nxt = w_short_res;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = StRun;
                    end
`else
                    w_load      = 1'b1;
                    w_state_nxt = StRun;
`endif
                end
            end
            StRun: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt  = StDone;
                    w_result_nxt = w_fin;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (i_flush) begin
            w_state_nxt  = StIdle;
            w_result_nxt = r_result;
            w_load       = 1'b0;
            w_step       = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            if (w_load) begin
                r_is_rem <= i_op[1];
                r_neg_q  <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
                r_neg_r  <= w_a_neg;
            end
        end
    end

    assign o_stall  = ~i_flush & (((r_state == StIdle) & i_start) | (r_state == StRun));
    assign o_valid  = (r_state == StDone) & ~i_flush;
    assign o_result = r_result;

endmodule
